// File: rtl/lfsr_prng_gen_pkg.sv
// Shared constants and types for the LFSR pseudo-random word generator.
// Includes the reference maximal-length tap masks used by the test fabric.
package lfsr_pkg;

  localparam logic MODE_FIB = 1'b0;
  localparam logic MODE_GAL = 1'b1;

  typedef enum logic {
    S_STEP  = 1'b0,
    S_VALID = 1'b1
  } fsm_state_t;

  localparam logic [7:0]  TAPS8_FIB  = 8'hB8;
  localparam logic [7:0]  TAPS8_GAL  = 8'h1D;
  localparam logic [15:0] TAPS16_FIB = 16'hB400;

endpackage

// File: rtl/lfsr_prng_gen_step_comb.sv
// One LFSR shift, Fibonacci or Galois, as pure combinational logic.
// The zero flag lets the caller substitute its recovery seed.
module lfsr_step_comb
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] state,
  input  logic [WIDTH-1:0] taps,
  input  logic             mode,
  output logic [WIDTH-1:0] next_state,
  output logic             zero
);

  always_comb begin
    next_state = '0;
    if (mode == MODE_GAL) begin
      next_state = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? taps : '0);
    end else begin
      next_state = {state[WIDTH-2:0], ^(state & taps)};
    end
  end

  assign zero = (next_state == '0);

endmodule

// File: rtl/lfsr_prng_gen.sv
// Parametrised LFSR word generator: STEPS shifts per word, valid/ready output,
// run-time reloadable seed/taps/structure and all-zero lock-up recovery.
module lfsr_prng_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter int               STEPS        = 1,
  parameter logic [WIDTH-1:0] DEFAULT_TAPS = 16'hB400,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'h0001,
  parameter logic             DEFAULT_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic [WIDTH-1:0] taps_in,
  input  logic             mode_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             lockup
);

  localparam int             CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_STEP = CW'(STEPS - 1);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] taps_q, taps_d;
  logic             mode_q, mode_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  fsm_state_t       fsm_q, fsm_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             lockup_q, lockup_d;

  logic [WIDTH-1:0] step_next;
  logic             step_zero;
  logic [WIDTH-1:0] step_state;
  logic             take_step;

  lfsr_step_comb #(
    .WIDTH(WIDTH)
  ) u_step (
    .state      (state_q),
    .taps       (taps_q),
    .mode       (mode_q),
    .next_state (step_next),
    .zero       (step_zero)
  );

  // A shift that would land on all-zero restarts from the default seed instead.
  assign step_state = step_zero ? DEFAULT_SEED : step_next;

  always_comb begin
    state_d   = state_q;
    taps_d    = taps_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    fsm_d     = fsm_q;
    data_d    = data_q;
    lockup_d  = lockup_q;
    take_step = 1'b0;

    if (seed_load) begin
      state_d  = (seed_in == '0) ? DEFAULT_SEED : seed_in;
      lockup_d = (seed_in == '0);
      taps_d   = taps_in;
      mode_d   = mode_in;
      cnt_d    = '0;
      fsm_d    = S_STEP;
    end else begin
      unique case (fsm_q)
        S_STEP:  take_step = en;
        S_VALID: begin
          if (out_ready) begin
            take_step = en;
            fsm_d     = S_STEP;
          end
        end
        default: fsm_d = S_STEP;
      endcase

      // A completed word overrides the handshake's return to S_STEP.
      if (take_step) begin
        state_d  = step_state;
        lockup_d = lockup_q | step_zero;
        if (cnt_q == LAST_STEP) begin
          cnt_d  = '0;
          data_d = step_state;
          fsm_d  = S_VALID;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= DEFAULT_SEED;
      taps_q   <= DEFAULT_TAPS;
      mode_q   <= DEFAULT_MODE;
      cnt_q    <= '0;
      fsm_q    <= S_STEP;
      data_q   <= '0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      taps_q   <= taps_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      fsm_q    <= fsm_d;
      data_q   <= data_d;
      lockup_q <= lockup_d;
    end
  end

  assign out_valid = (fsm_q == S_VALID);
  assign out_data  = data_q;
  assign lockup    = lockup_q;

endmodule
